// File: rtl/rca_sum_accumulator.sv
// Frame accumulator for the 5-bit ripple-carry adder result: sums up to
// FRAME_LEN samples and presents total, count and sticky overflow for handoff.
module rca_sum_accumulator #(
   parameter int ACC_W     = 16,
   parameter int FRAME_LEN = 8,
   parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             s0,
   input  logic             s1,
   input  logic             s2,
   input  logic             s3,
   input  logic             s4,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   // Handshake: a transfer happens on a rising edge where valid && ready.
   // in_ready depends on state only; out_valid holds until out_ready is seen.
   typedef enum logic {ACCUM, HOLD} state_t;

   state_t           state, state_nxt;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;

   logic [4:0]       sum5;
   logic [ACC_W:0]   next;
   logic [CNT_W-1:0] cnt_inc;
   logic             accept;
   logic             is_final;

   assign sum5     = {s4, s3, s2, s1, s0};
   assign next     = {1'b0, acc} + {{(ACC_W - 4){1'b0}}, sum5};
   assign cnt_inc  = cnt + CNT_W'(1);
   assign in_ready = (state == ACCUM);
   assign out_valid = (state == HOLD);
   assign accept   = in_valid && in_ready;
   // A full frame closes even without in_last.
   assign is_final = in_last || (cnt == CNT_W'(FRAME_LEN - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM: if (accept && is_final) state_nxt = HOLD;
         HOLD:  if (out_ready) state_nxt = ACCUM;
         default: state_nxt = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACCUM;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            if (is_final) begin
               out_sum   <= next[ACC_W-1:0];
               out_ovf   <= ovf | next[ACC_W];
               out_count <= cnt_inc;
               acc       <= '0;
               cnt       <= '0;
               ovf       <= 1'b0;
            end else begin
               acc <= next[ACC_W-1:0];
               ovf <= ovf | next[ACC_W];
               cnt <= cnt_inc;
            end
         end
      end
   end

endmodule

// File: tb/tb_rca_sum_accumulator.sv
// Directed bench: three parameterisations driven from shared inputs, each
// checked only in the scenarios where its parameters matter.
module tb_rca_sum_accumulator;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [4:0] s;
   logic       in_last;
   logic       out_ready;

   logic        a_in_ready, a_out_valid, a_out_ovf;
   logic [15:0] a_out_sum;
   logic [3:0]  a_out_count;
   logic        b_in_ready, b_out_valid, b_out_ovf;
   logic [6:0]  b_out_sum;
   logic [3:0]  b_out_count;
   logic        c_in_ready, c_out_valid, c_out_ovf;
   logic [15:0] c_out_sum;
   logic [2:0]  c_out_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rca_sum_accumulator #(.ACC_W(16), .FRAME_LEN(8)) u_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
      .s0(s[0]), .s1(s[1]), .s2(s[2]), .s3(s[3]), .s4(s[4]), .in_last(in_last),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_sum(a_out_sum),
      .out_count(a_out_count), .out_ovf(a_out_ovf));

   rca_sum_accumulator #(.ACC_W(7), .FRAME_LEN(8)) u_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
      .s0(s[0]), .s1(s[1]), .s2(s[2]), .s3(s[3]), .s4(s[4]), .in_last(in_last),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_sum(b_out_sum),
      .out_count(b_out_count), .out_ovf(b_out_ovf));

   rca_sum_accumulator #(.ACC_W(16), .FRAME_LEN(4)) u_c (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
      .s0(s[0]), .s1(s[1]), .s2(s[2]), .s3(s[3]), .s4(s[4]), .in_last(in_last),
      .out_valid(c_out_valid), .out_ready(out_ready), .out_sum(c_out_sum),
      .out_count(c_out_count), .out_ovf(c_out_ovf));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are read there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [4:0] v, input logic last);
      in_valid = 1'b1;
      s        = v;
      in_last  = last;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; s = '0; in_last = 1'b0; out_ready = 1'b0;
      #1;
      do_reset();
      chk("rst_valid", 32'(a_out_valid), 0);
      chk("rst_ready", 32'(a_in_ready), 1);
      chk("rst_sum",   32'(a_out_sum), 0);
      chk("rst_count", 32'(a_out_count), 0);
      chk("rst_ovf",   32'(a_out_ovf), 0);

      // Full frame of 30s: 240 in 16 bits, wraps to 112 with overflow in 7 bits.
      for (int i = 0; i < 7; i++) send(5'd30, 1'b0);
      chk("full_not_yet", 32'(a_out_valid), 0);
      send(5'd30, 1'b0);
      chk("full_valid", 32'(a_out_valid), 1);
      chk("full_sum",   32'(a_out_sum), 240);
      chk("full_count", 32'(a_out_count), 8);
      chk("full_ovf",   32'(a_out_ovf), 0);
      chk("full_ready", 32'(a_in_ready), 0);
      chk("wrap_sum",   32'(b_out_sum), 112);
      chk("wrap_count", 32'(b_out_count), 8);
      chk("wrap_ovf",   32'(b_out_ovf), 1);
      handshake();
      chk("hs_valid", 32'(b_out_valid), 0);
      chk("hs_ready", 32'(b_in_ready), 1);
      send(5'd1, 1'b0);
      send(5'd2, 1'b1);
      chk("f2_valid", 32'(b_out_valid), 1);
      chk("f2_sum",   32'(b_out_sum), 3);
      chk("f2_count", 32'(b_out_count), 2);
      chk("f2_ovf",   32'(b_out_ovf), 0);
      handshake();

      // in_last without in_valid must not close anything.
      do_reset();
      in_last = 1'b1;
      step(); step();
      in_last = 1'b0;
      chk("idle_last_valid", 32'(a_out_valid), 0);
      chk("idle_last_ready", 32'(a_in_ready), 1);
      send(5'd5, 1'b0);
      send(5'd10, 1'b0);
      send(5'd30, 1'b1);
      chk("early_valid", 32'(a_out_valid), 1);
      chk("early_sum",   32'(a_out_sum), 45);
      chk("early_count", 32'(a_out_count), 3);

      // Backpressure with a pending input.
      in_valid = 1'b1; s = 5'd7; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_valid", 32'(a_out_valid), 1);
         chk("bp_ready", 32'(a_in_ready), 0);
         chk("bp_sum",   32'(a_out_sum), 45);
         chk("bp_count", 32'(a_out_count), 3);
         chk("bp_ovf",   32'(a_out_ovf), 0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("bp_rel_valid", 32'(a_out_valid), 0);
      chk("bp_rel_ready", 32'(a_in_ready), 1);
      step();
      in_valid = 1'b0; in_last = 1'b0;
      chk("bp_next_valid", 32'(a_out_valid), 1);
      chk("bp_next_sum",   32'(a_out_sum), 7);
      chk("bp_next_count", 32'(a_out_count), 1);
      handshake();

      // Reset mid-frame discards the partial 80.
      do_reset();
      for (int i = 0; i < 4; i++) send(5'd20, 1'b0);
      do_reset();
      chk("mid_rst_valid", 32'(a_out_valid), 0);
      chk("mid_rst_ready", 32'(a_in_ready), 1);
      chk("mid_rst_sum",   32'(a_out_sum), 0);
      chk("mid_rst_count", 32'(a_out_count), 0);
      for (int i = 0; i < 8; i++) send(5'd1, 1'b0);
      chk("after_rst_sum",   32'(a_out_sum), 8);
      chk("after_rst_count", 32'(a_out_count), 8);
      chk("after_rst_ovf",   32'(a_out_ovf), 0);

      // Gapped input on the FRAME_LEN=4 instance, full 5-bit value 31.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         send(5'd31, 1'b0);
         step();
      end
      chk("gap_not_yet", 32'(c_out_valid), 0);
      send(5'd31, 1'b0);
      chk("gap_valid", 32'(c_out_valid), 1);
      chk("gap_sum",   32'(c_out_sum), 124);
      chk("gap_count", 32'(c_out_count), 4);
      chk("gap_ready", 32'(c_in_ready), 0);
      chk("gap_wide_open", 32'(a_out_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
